// File: rtl/mem_arb_defs.sv
// Shared definitions for the two-port memory access arbiter:
// FSM state encoding, requester IDs and array rw encodings.
package mem_arb_defs;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  localparam logic RQ0 = 1'b0;
  localparam logic RQ1 = 1'b1;

  localparam logic MEM_RW_WRITE = 1'b0;
  localparam logic MEM_RW_READ  = 1'b1;

endpackage

// File: rtl/arb2_rr.sv
// Two-input picker. Default: round-robin, pointer remembers the last winner
// so the other requester wins a tie; a single requester always wins.
// With MEM_ARB_FIXED_PRIO_EN defined: requester 0 wins every tie, no pointer.
module arb2_rr
  import mem_arb_defs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       win_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 first.
  always_comb win_o = req_i[0] ? RQ0 : RQ1;
`else
  logic last_q, last_d;

  // Pick the winner and advance the pointer whenever a grant is taken.
  always_comb begin
    last_d = last_q;
    if (req_i == 2'b11) win_o = ~last_q;
    else if (req_i[1])  win_o = RQ1;
    else                win_o = RQ0;
    if (take_i) last_d = win_o;
  end

  // Pointer register; reset value makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_q <= RQ1;
    else     last_q <= last_d;
  end
`endif

endmodule

// File: rtl/mem_access_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port bit-cell array.
// IDLE arbitrates and issues; ISSUE drives select for one cycle; RDWAIT
// captures the registered array output. All outputs are registered.
// Optional macro: MEM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module mem_access_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq0_req,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  output logic              rq0_gnt,
  output logic              rq0_done,
  output logic [DATA_W-1:0] rq0_rdata,
  input  logic              rq1_req,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq1_gnt,
  output logic              rq1_done,
  output logic [DATA_W-1:0] rq1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_select,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  state_e            state_q, state_d;
  logic              cmd_we_q, cmd_we_d;
  logic              cmd_id_q, cmd_id_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              sel_q, sel_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] in_q, in_d;
  logic              win, take;

  arb2_rr u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_i  ({rq1_req, rq0_req}),
    .take_i (take),
    .win_o  (win)
  );

  // Next-state and registered-output logic. The array command registers
  // double as the latched request address/data for the ISSUE cycle.
  always_comb begin
    state_d  = state_q;
    cmd_we_d = cmd_we_q;
    cmd_id_d = cmd_id_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sel_d    = 1'b0;
    rw_d     = rw_q;
    addr_d   = addr_q;
    in_d     = in_q;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rq0_req || rq1_req) begin
          take     = 1'b1;
          cmd_id_d = win;
          cmd_we_d = (win == RQ0) ? rq0_we : rq1_we;
          addr_d   = (win == RQ0) ? rq0_addr : rq1_addr;
          in_d     = cmd_we_d ? ((win == RQ0) ? rq0_wdata : rq1_wdata) : '0;
          rw_d     = cmd_we_d ? MEM_RW_WRITE : MEM_RW_READ;
          sel_d    = 1'b1;
          gnt0_d   = (win == RQ0);
          gnt1_d   = (win == RQ1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_we_q) begin
          done0_d = (cmd_id_q == RQ0);
          done1_d = (cmd_id_q == RQ1);
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cmd_id_q == RQ0) rdata0_d = mem_out;
        else                 rdata1_d = mem_out;
        done0_d = (cmd_id_q == RQ0);
        done1_d = (cmd_id_q == RQ1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_we_q <= 1'b0;
      cmd_id_q <= RQ0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      sel_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      in_q     <= '0;
    end else begin
      state_q  <= state_d;
      cmd_we_q <= cmd_we_d;
      cmd_id_q <= cmd_id_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      sel_q    <= sel_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      in_q     <= in_d;
    end
  end

  assign rq0_gnt    = gnt0_q;
  assign rq1_gnt    = gnt1_q;
  assign rq0_done   = done0_q;
  assign rq1_done   = done1_q;
  assign rq0_rdata  = rdata0_q;
  assign rq1_rdata  = rdata1_q;
  assign mem_select = sel_q;
  assign mem_rw     = rw_q;
  assign mem_addr   = addr_q;
  assign mem_in     = in_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural bit-cell array.
module tb_mem_access_arbiter;

  logic       clk, rst;
  logic       rq0_req, rq0_we, rq1_req, rq1_we;
  logic [3:0] rq0_addr, rq1_addr, mem_addr;
  logic [7:0] rq0_wdata, rq1_wdata, rq0_rdata, rq1_rdata, mem_in, mem_out;
  logic       rq0_gnt, rq0_done, rq1_gnt, rq1_done, mem_select, mem_rw;
  logic [7:0] mem [16];
  int         checks = 0;
  int         fails  = 0;

  mem_access_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_gnt(rq0_gnt), .rq0_done(rq0_done), .rq0_rdata(rq0_rdata),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_gnt(rq1_gnt), .rq1_done(rq1_done), .rq1_rdata(rq1_rdata),
    .mem_addr(mem_addr), .mem_select(mem_select), .mem_rw(mem_rw),
    .mem_in(mem_in), .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array: write on select with rw=0, registered read on select with rw=1.
  always @(posedge clk) begin
    if (mem_select) begin
      if (!mem_rw) mem[mem_addr] <= mem_in;
      else         mem_out <= mem[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({rq0_gnt, rq0_done, rq0_rdata, rq1_gnt, rq1_done, rq1_rdata,
           mem_addr, mem_select, mem_rw, mem_in} !== 34'h0) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: outputs not all zero (sel=%b gnt=%b%b done=%b%b addr=%h in=%h)",
                 i, mem_select, rq0_gnt, rq1_gnt, rq0_done, rq1_done, mem_addr, mem_in);
      end
    end
  endtask

  task automatic test_write_read();
    rq0_req = 1'b1; rq0_we = 1'b1; rq0_addr = 4'h3; rq0_wdata = 8'hA5;
    step();
    checks++;
    if ({rq0_gnt, rq1_gnt, mem_select, mem_rw, mem_addr, mem_in} !== {4'b1010, 4'h3, 8'hA5}) begin
      fails++;
      $display("FAIL wr_issue: gnt0=%b gnt1=%b sel=%b rw=%b addr=%h in=%h, required 1 0 1 0 3 a5",
               rq0_gnt, rq1_gnt, mem_select, mem_rw, mem_addr, mem_in);
    end
    rq0_req = 1'b0;
    step();
    checks++;
    if ({rq0_done, mem_select} !== 2'b10) begin
      fails++;
      $display("FAIL wr_done: done0=%b sel=%b, required 1 0", rq0_done, mem_select);
    end
    rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 4'h3; rq1_wdata = 8'hFF;
    step();
    checks++;
    if ({rq1_gnt, mem_select, mem_rw, mem_addr, mem_in} !== {3'b111, 4'h3, 8'h00}) begin
      fails++;
      $display("FAIL rd_issue: gnt1=%b sel=%b rw=%b addr=%h in=%h, required 1 1 1 3 00",
               rq1_gnt, mem_select, mem_rw, mem_addr, mem_in);
    end
    rq1_req = 1'b0;
    step();
    checks++;
    if ({rq1_done, mem_select} !== 2'b00) begin
      fails++;
      $display("FAIL rd_wait: done1=%b sel=%b, required 0 0", rq1_done, mem_select);
    end
    step();
    checks++;
    if ({rq1_done, rq1_rdata, rq0_done, rq0_rdata} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL rd_done: done1=%b rdata1=%h done0=%b rdata0=%h, required 1 a5 0 00",
               rq1_done, rq1_rdata, rq0_done, rq0_rdata);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] order;
    int         n;
    logic [3:0] exp_order;
    n = 0;
    order = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_order = 4'b0000;
`else
    exp_order = 4'b1010;
`endif
    rq0_req = 1'b1; rq0_we = 1'b1; rq0_addr = 4'h5; rq0_wdata = 8'h3C;
    rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 4'h3;
    for (int c = 0; c < 30 && n < 4; c++) begin
      step();
      if (rq0_gnt && rq1_gnt) begin
        checks++;
        fails++;
        $display("FAIL arb_double_gnt at cycle %0d: both grants high, required one", c);
      end
      if (rq1_done) begin
        checks++;
        if (rq1_rdata !== 8'hA5) begin
          fails++;
          $display("FAIL arb_rd1_data: rdata1=%h required a5", rq1_rdata);
        end
      end
      if (rq0_gnt || rq1_gnt) begin
        order[n] = rq1_gnt;
        n++;
      end
    end
    rq0_req = 1'b0;
    rq1_req = 1'b0;
    checks++;
    if (n != 4) begin
      fails++;
      $display("FAIL arb_timeout: saw %0d grants, required 4", n);
    end
    checks++;
    if (order !== exp_order) begin
      fails++;
      $display("FAIL arb_order: grant ids (first in bit0) %b, required %b", order, exp_order);
    end
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_back_to_back();
    rq0_req = 1'b1; rq0_we = 1'b0; rq0_addr = 4'h1;
    step();
    checks++;
    if ({rq0_gnt, mem_addr} !== {1'b1, 4'h1}) begin
      fails++;
      $display("FAIL b2b_gnt1: gnt0=%b addr=%h, required 1 1", rq0_gnt, mem_addr);
    end
    rq0_addr = 4'h2;
    step();
    step();
    checks++;
    if ({rq0_done, rq0_rdata} !== {1'b1, 8'h0F}) begin
      fails++;
      $display("FAIL b2b_done1: done0=%b rdata0=%h, required 1 0f", rq0_done, rq0_rdata);
    end
    step();
    checks++;
    if ({rq0_gnt, rq0_done, mem_addr} !== {2'b10, 4'h2}) begin
      fails++;
      $display("FAIL b2b_gnt2: gnt0=%b done0=%b addr=%h, required 1 0 2", rq0_gnt, rq0_done, mem_addr);
    end
    rq0_req = 1'b0;
    step();
    checks++;
    if ({rq0_done, rq0_rdata} !== {1'b0, 8'h0F}) begin
      fails++;
      $display("FAIL b2b_wait2: done0=%b rdata0=%h, required 0 0f", rq0_done, rq0_rdata);
    end
    step();
    checks++;
    if ({rq0_done, rq0_rdata} !== {1'b1, 8'hF0}) begin
      fails++;
      $display("FAIL b2b_done2: done0=%b rdata0=%h, required 1 f0", rq0_done, rq0_rdata);
    end
  endtask

  task automatic test_reset_midop();
    step();
    rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 4'h5;
    step();
    checks++;
    if (rq1_gnt !== 1'b1) begin
      fails++;
      $display("FAIL midrst_gnt: gnt1=%b required 1", rq1_gnt);
    end
    rq1_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({rq1_done, rq0_done, rq1_gnt, mem_select} !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_quiet: done1=%b done0=%b gnt1=%b sel=%b, required all 0",
               rq1_done, rq0_done, rq1_gnt, mem_select);
    end
    checks++;
    if (rq1_rdata === 8'h3C) begin
      fails++;
      $display("FAIL midrst_rdata: rdata1=%h, required anything but aborted data 3c", rq1_rdata);
    end
    rst = 1'b0;
    rq1_req = 1'b1; rq1_we = 1'b0; rq1_addr = 4'h5;
    step();
    checks++;
    if ({rq1_gnt, mem_select, mem_addr} !== {2'b11, 4'h5}) begin
      fails++;
      $display("FAIL midrst_regnt: gnt1=%b sel=%b addr=%h, required 1 1 5", rq1_gnt, mem_select, mem_addr);
    end
    rq1_req = 1'b0;
    step();
    step();
    checks++;
    if ({rq1_done, rq1_rdata} !== {1'b1, 8'h3C}) begin
      fails++;
      $display("FAIL midrst_redone: done1=%b rdata1=%h, required 1 3c", rq1_done, rq1_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[1] = 8'h0F;
    mem[2] = 8'hF0;
    mem_out = 8'h00;
    rst = 1'b1;
    rq0_req = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
    rq1_req = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
    test_reset();
    test_write_read();
    test_arbitration();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
